// File: rtl/regfile_wr_arbiter.sv
// Purpose: shares the register-file write port between core writeback and the debug port, round-robin on conflict.
// Latency: one cycle from an accepted request to the registered rf_we/rf_addr/rf_data beat.
// Backpressure: the refused requester sees ready=0 and must hold its request; refusals are counted in stall_cnt.
// Optional feature macro: RF_SCRUB_EN (post-reset zero-fill of x1..x(NUM_REGS-1) before arbitration starts).
module regfile_wr_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int STALL_W  = 16
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               core_valid,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic [DATA_W-1:0]  core_data,
  output logic               core_ready,
  input  logic               dbg_valid,
  input  logic [ADDR_W-1:0]  dbg_addr,
  input  logic [DATA_W-1:0]  dbg_data,
  output logic               dbg_ready,
  output logic               rf_we,
  output logic [ADDR_W-1:0]  rf_addr,
  output logic [DATA_W-1:0]  rf_data,
  output logic               init_done,
  output logic [STALL_W-1:0] stall_cnt
);

  // When every encodable address is a real register, only x0 needs filtering.
  localparam bit LP_FULL_MAP = (NUM_REGS >= (1 << ADDR_W));

  logic               r_rf_we;
  logic [ADDR_W-1:0]  r_rf_addr;
  logic [DATA_W-1:0]  r_rf_data;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_last_dbg;   // 1 = debug won the most recent transfer
  logic               w_run;
  logic               w_core_xfer;
  logic               w_dbg_xfer;
  logic               w_core_wr;
  logic               w_dbg_wr;
  logic               w_stall_evt;

`ifdef RF_SCRUB_EN
  typedef enum logic {ST_SCRUB, ST_RUN} state_t;
  state_t             r_state;
  logic [ADDR_W-1:0]  r_scrub_cnt;
  logic               r_init_done;

  assign w_run     = (r_state == ST_RUN);
  assign init_done = r_init_done;
`else
  assign w_run     = 1'b1;
  assign init_done = 1'b1;
`endif

  // Grant: a lone requester wins; on conflict the one that did not win last time wins.
  assign core_ready = w_run && core_valid && (!dbg_valid || r_last_dbg);
  assign dbg_ready  = w_run && dbg_valid && (!core_valid || !r_last_dbg);

  assign w_core_xfer = core_valid && core_ready;
  assign w_dbg_xfer  = dbg_valid && dbg_ready;

  // x0 is hard-wired zero and out-of-range registers do not exist: accept but do not write.
  assign w_core_wr = (core_addr != '0) && (LP_FULL_MAP || (int'(core_addr) < NUM_REGS));
  assign w_dbg_wr  = (dbg_addr != '0) && (LP_FULL_MAP || (int'(dbg_addr) < NUM_REGS));

  assign w_stall_evt = (core_valid && !core_ready) || (dbg_valid && !dbg_ready);

  assign rf_we     = r_rf_we;
  assign rf_addr   = r_rf_addr;
  assign rf_data   = r_rf_data;
  assign stall_cnt = r_stall_cnt;

  // Control FSM and write beat: scrub (if built in) then one registered beat per accepted request.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
      r_last_dbg <= 1'b1;
`ifdef RF_SCRUB_EN
      r_state     <= ST_SCRUB;
      r_scrub_cnt <= ADDR_W'(1);
      r_init_done <= 1'b0;
`endif
    end else begin
`ifdef RF_SCRUB_EN
      if (r_state == ST_SCRUB) begin
        r_rf_we     <= 1'b1;
        r_rf_addr   <= r_scrub_cnt;
        r_rf_data   <= '0;
        r_scrub_cnt <= r_scrub_cnt + 1'b1;
        if (r_scrub_cnt == ADDR_W'(NUM_REGS - 1)) begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
      end else begin
`else
      begin
`endif
        r_rf_we <= 1'b0;
        if (w_core_xfer) begin
          r_last_dbg <= 1'b0;
          if (w_core_wr) begin
            r_rf_we   <= 1'b1;
            r_rf_addr <= core_addr;
            r_rf_data <= core_data;
          end
        end else if (w_dbg_xfer) begin
          r_last_dbg <= 1'b1;
          if (w_dbg_wr) begin
            r_rf_we   <= 1'b1;
            r_rf_addr <= dbg_addr;
            r_rf_data <= dbg_data;
          end
        end
      end
    end
  end

  // Saturating count of arbitration cycles in which some valid requester was refused.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_stall_cnt <= '0;
    end else if (w_run && w_stall_evt && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: vector table, randomized traffic against a reference model,
// reset-abort and stall-counter saturation sequences; scrub sequences when RF_SCRUB_EN is defined.
module tb_regfile_wr_arbiter;

`ifdef RF_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic        wb_clk;
  logic        wb_rst;
  logic        core_valid;
  logic [4:0]  core_addr;
  logic [31:0] core_data;
  logic        core_ready;
  logic        dbg_valid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        init_done;
  logic [15:0] stall_cnt;

  regfile_wr_arbiter dut (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .core_valid (core_valid),
    .core_addr  (core_addr),
    .core_data  (core_data),
    .core_ready (core_ready),
    .dbg_valid  (dbg_valid),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_ready  (dbg_ready),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .init_done  (init_done),
    .stall_cnt  (stall_cnt)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: who won last, saturating stall total, last visible write beat.
  int          m_last;      // 0 = core, 1 = debug
  int          m_stall;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_ad_known;

  function automatic int pick(input logic cv, input logic dv);
    if (cv && dv) return (m_last == 1) ? 0 : 1;
    if (cv) return 0;
    if (dv) return 1;
    return -1;
  endfunction

  task automatic drive(input logic cv, input logic [4:0] ca, input logic [31:0] cd,
                       input logic dv, input logic [4:0] da, input logic [31:0] dd);
    core_valid = cv; core_addr = ca; core_data = cd;
    dbg_valid  = dv; dbg_addr  = da; dbg_data  = dd;
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("rst rf_we", 32'(rf_we), 32'd0);
    chk("rst rf_addr", 32'(rf_addr), 32'd0);
    chk("rst rf_data", rf_data, 32'd0);
    chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst init_done", 32'(init_done), SCRUB ? 32'd0 : 32'd1);
    @(negedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    m_last = 1; m_stall = 0; m_we = 1'b0; m_data = 32'h0; m_ad_known = 1'b1;
    m_addr = SCRUB ? 5'd31 : 5'd0;
`ifdef RF_SCRUB_EN
    // Requests are held pending through the scrub: they must be neither granted nor counted.
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    for (int i = 1; i <= 31; i++) begin
      #1;
      chk($sformatf("scrub%0d core_ready", i), 32'(core_ready), 32'd0);
      chk($sformatf("scrub%0d dbg_ready", i), 32'(dbg_ready), 32'd0);
      @(posedge wb_clk);
      #1;
      chk($sformatf("scrub%0d rf_we", i), 32'(rf_we), 32'd1);
      chk($sformatf("scrub%0d rf_addr", i), 32'(rf_addr), 32'(i));
      chk($sformatf("scrub%0d rf_data", i), rf_data, 32'd0);
      chk($sformatf("scrub%0d init_done", i), 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
      @(negedge wb_clk);
    end
    chk("scrub stall_cnt", 32'(stall_cnt), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`endif
  endtask

  task automatic rcycle(input logic cv, input logic [4:0] ca, input logic [31:0] cd,
                        input logic dv, input logic [4:0] da, input logic [31:0] dd,
                        output int w);
    @(negedge wb_clk);
    drive(cv, ca, cd, dv, da, dd);
    #1;
    w = pick(cv, dv);
    chk("rnd core_ready", 32'(core_ready), 32'(w == 0));
    chk("rnd dbg_ready", 32'(dbg_ready), 32'(w == 1));
    m_we = 1'b0;
    if (w >= 0) begin
      m_last = w;
      if (((w == 0) ? ca : da) != 5'd0) begin
        m_we = 1'b1; m_ad_known = 1'b1;
        m_addr = (w == 0) ? ca : da;
        m_data = (w == 0) ? cd : dd;
      end else begin
        m_ad_known = 1'b0;
      end
    end
    if ((cv && w != 0) || (dv && w != 1)) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
    @(posedge wb_clk);
    #1;
    chk("rnd rf_we", 32'(rf_we), 32'(m_we));
    if (m_ad_known) begin
      chk("rnd rf_addr", 32'(rf_addr), 32'(m_addr));
      chk("rnd rf_data", rf_data, m_data);
    end
    chk("rnd stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  typedef struct {
    logic cv; logic [4:0] ca; logic [31:0] cd;
    logic dv; logic [4:0] da; logic [31:0] dd;
    logic cr; logic dr; logic we; logic ck_ad;
    logic [4:0] ea; logic [31:0] ed; logic [15:0] es;
  } vec_t;

  vec_t tv[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic cp, dp;
    logic [4:0] ca_r, da_r;
    logic [31:0] cd_r, dd_r;

    //           cv    ca     cd            dv    da     dd            cr    dr    we    ck    ea     ed            stall
    tv[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        16'd0};
    tv[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 16'd0};
    tv[2]  = '{1'b1, 5'd3,  32'h33333333, 1'b1, 5'd4,  32'h44444444, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  32'h44444444, 16'd1};
    tv[3]  = '{1'b1, 5'd3,  32'h33333333, 1'b1, 5'd4,  32'h44444444, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  32'h33333333, 16'd2};
    tv[4]  = '{1'b1, 5'd3,  32'h33333333, 1'b1, 5'd4,  32'h44444444, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  32'h44444444, 16'd3};
    tv[5]  = '{1'b1, 5'd3,  32'h33333333, 1'b1, 5'd4,  32'h44444444, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  32'h33333333, 16'd4};
    tv[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44444444, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  32'h44444444, 16'd4};
    tv[7]  = '{1'b1, 5'd9,  32'h99999999, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  32'h99999999, 16'd4};
    tv[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0BADF00D, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        16'd4};
    tv[9]  = '{1'b1, 5'd10, 32'hAAAA0000, 1'b1, 5'd11, 32'hBBBB0000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'hAAAA0000, 16'd5};
    tv[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'hBBBB0000, 1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 32'hBBBB0000, 16'd5};
    tv[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'hBBBB0000, 16'd5};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      @(negedge wb_clk);
      drive(tv[i].cv, tv[i].ca, tv[i].cd, tv[i].dv, tv[i].da, tv[i].dd);
      #1;
      chk($sformatf("tv%0d core_ready", i), 32'(core_ready), 32'(tv[i].cr));
      chk($sformatf("tv%0d dbg_ready", i), 32'(dbg_ready), 32'(tv[i].dr));
      @(posedge wb_clk);
      #1;
      chk($sformatf("tv%0d rf_we", i), 32'(rf_we), 32'(tv[i].we));
      if (tv[i].ck_ad) begin
        chk($sformatf("tv%0d rf_addr", i), 32'(rf_addr), 32'(tv[i].ea));
        chk($sformatf("tv%0d rf_data", i), rf_data, tv[i].ed);
      end
      chk($sformatf("tv%0d stall_cnt", i), 32'(stall_cnt), 32'(tv[i].es));
    end

    // Randomized traffic; a refused request is held until it is accepted.
    do_reset();
    cp = 1'b0; dp = 1'b0;
    ca_r = 5'd0; da_r = 5'd0; cd_r = 32'h0; dd_r = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if (!cp && ($urandom_range(0, 1) == 1)) begin
        cp = 1'b1;
        ca_r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        cd_r = $urandom;
      end
      if (!dp && ($urandom_range(0, 1) == 1)) begin
        dp = 1'b1;
        da_r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        dd_r = $urandom;
      end
      rcycle(cp, ca_r, cd_r, dp, da_r, dd_r, w);
      if (w == 0) cp = 1'b0;
      if (w == 1) dp = 1'b0;
    end

    // Reset in the middle of an accepted transfer: the pending beat is lost.
    rcycle(1'b1, 5'd2, 32'h12345678, 1'b0, 5'd0, 32'h0, w);
    @(negedge wb_clk);
    drive(1'b1, 5'd6, 32'h66666666, 1'b0, 5'd0, 32'h0);
    #1;
    chk("abort core_ready", 32'(core_ready), 32'd1);
    do_reset();
    rcycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, w);
    rcycle(1'b1, 5'd6, 32'h66666666, 1'b0, 5'd0, 32'h0, w);

`ifdef RF_SCRUB_EN
    // Reset while the scrub is at x10: outputs clear at once and the scrub restarts at x1.
    wb_rst = 1'b1;
    @(negedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (9) @(posedge wb_clk);
    #1;
    chk("midscrub rf_addr", 32'(rf_addr), 32'd9);
    wb_rst = 1'b1;
    #1;
    chk("midscrub rst rf_we", 32'(rf_we), 32'd0);
    chk("midscrub rst rf_addr", 32'(rf_addr), 32'd0);
    chk("midscrub rst init_done", 32'(init_done), 32'd0);
    do_reset();
`endif

    // Stall counter saturation: continuous conflict stalls one requester every cycle.
    do_reset();
    @(negedge wb_clk);
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    repeat (65534) @(posedge wb_clk);
    #1;
    chk("stall 0xFFFE", 32'(stall_cnt), 32'h0000FFFE);
    repeat (3) @(posedge wb_clk);
    #1;
    chk("stall saturated", 32'(stall_cnt), 32'h0000FFFF);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
